// File: rtl/vga_timing_gen.sv
// vga_timing_gen: programmable VGA raster timing; clk/reset in; hsync, vsync, hcount, vcount, pix_clk, pix_en, blank, line_end, frame_end, frame_count out; VGA_TIMING_FRAME_CNT_EN builds frame_count
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP = 33,
  parameter int CLK_DIV = 2,
  parameter int HSYNC_POL = 0,
  parameter int VSYNC_POL = 0,
  parameter int CNT_W = 10,
  parameter int FRAME_W = 8
) (
  input  logic clk,
  input  logic reset,
  output logic hsync,
  output logic vsync,
  output logic [CNT_W-1:0] hcount,
  output logic [CNT_W-1:0] vcount,
  output logic pix_clk,
  output logic pix_en,
  output logic blank,
  output logic line_end,
  output logic frame_end,
  output logic [FRAME_W-1:0] frame_count
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W = $clog2(CLK_DIV);
  localparam logic HP = HSYNC_POL != 0;
  localparam logic VP = VSYNC_POL != 0;
  logic [DIV_W-1:0] div_cnt, div_nxt;
  logic [CNT_W-1:0] h_nxt, v_nxt;
  logic h_in, v_in;
  assign pix_en = div_cnt == DIV_W'(CLK_DIV - 1);
  assign line_end = pix_en && hcount == CNT_W'(H_TOTAL - 1);
  assign frame_end = line_end && vcount == CNT_W'(V_TOTAL - 1);
  always_comb begin
    div_nxt = pix_en ? '0 : div_cnt + 1'b1;
    h_nxt = pix_en ? (line_end ? '0 : hcount + 1'b1) : hcount;
    v_nxt = line_end ? (frame_end ? '0 : vcount + 1'b1) : vcount;
    h_in = h_nxt >= CNT_W'(H_ACTIVE + H_FP) && h_nxt < CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    v_in = v_nxt >= CNT_W'(V_ACTIVE + V_FP) && v_nxt < CNT_W'(V_ACTIVE + V_FP + V_SYNC);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt <= '0;
      hcount <= '0;
      vcount <= '0;
      pix_clk <= 1'b0;
      hsync <= !HP;
      vsync <= !VP;
      blank <= 1'b0;
    end else begin
      div_cnt <= div_nxt;
      hcount <= h_nxt;
      vcount <= v_nxt;
      pix_clk <= div_nxt >= DIV_W'(CLK_DIV / 2);
      hsync <= h_in ? HP : !HP;
      vsync <= v_in ? VP : !VP;
      blank <= h_nxt >= CNT_W'(H_ACTIVE) || v_nxt >= CNT_W'(V_ACTIVE);
    end
  end
`ifdef VGA_TIMING_FRAME_CNT_EN
  always_ff @(posedge clk)
    frame_count <= reset ? '0 : frame_count + FRAME_W'(frame_end);
`else
  assign frame_count = '0;
`endif
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed checks of vga_timing_gen at default, tiny and mid-size modes
module tb_vga_timing_gen;
  logic clk = 1'b0;
  logic rst_a = 1'b1, rst_b = 1'b1, rst_c = 1'b1;
  logic hs_a, vs_a, pc_a, pe_a, bl_a, le_a, fe_a;
  logic hs_b, vs_b, pc_b, pe_b, bl_b, le_b, fe_b;
  logic hs_c, vs_c, pc_c, pe_c, bl_c, le_c, fe_c;
  logic [9:0] h_a, v_a, h_b, v_b, h_c, v_c;
  logic [7:0] fc_a, fc_c;
  logic [1:0] fc_b;
  int n = 0, err = 0;
  int ka = 0, kb = 0, kc = 0;
  int hsl = 0, lec = 0, pcn = 0, vsn = 0;
  bit fe_seen = 0;
  int fek[$];
  int fcs[$];
  always #5 clk = ~clk;

  vga_timing_gen u_a (
    .clk(clk), .reset(rst_a), .hsync(hs_a), .vsync(vs_a), .hcount(h_a), .vcount(v_a),
    .pix_clk(pc_a), .pix_en(pe_a), .blank(bl_a), .line_end(le_a), .frame_end(fe_a),
    .frame_count(fc_a));

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2), .V_ACTIVE(4), .V_FP(1), .V_SYNC(1),
    .V_BP(1), .CLK_DIV(3), .HSYNC_POL(1), .FRAME_W(2)
  ) u_b (
    .clk(clk), .reset(rst_b), .hsync(hs_b), .vsync(vs_b), .hcount(h_b), .vcount(v_b),
    .pix_clk(pc_b), .pix_en(pe_b), .blank(bl_b), .line_end(le_b), .frame_end(fe_b),
    .frame_count(fc_b));

  vga_timing_gen #(
    .H_ACTIVE(20), .H_FP(4), .H_SYNC(6), .H_BP(2), .V_ACTIVE(10), .V_FP(3), .V_SYNC(2),
    .V_BP(4), .CLK_DIV(4), .VSYNC_POL(1)
  ) u_c (
    .clk(clk), .reset(rst_c), .hsync(hs_c), .vsync(vs_c), .hcount(h_c), .vcount(v_c),
    .pix_clk(pc_c), .pix_en(pe_c), .blank(bl_c), .line_end(le_c), .frame_end(fe_c),
    .frame_count(fc_c));

  task automatic cmp(input string nm, input int a, input int e);
    n++;
    if (a != e) begin
      err++;
      $display("FAIL %s: got %0d want %0d", nm, a, e);
    end
  endtask

  // k = clk edges since the last reset edge; expectations follow from k alone
  task automatic chk(input string tag, input int k, input int d, input int ht, input int vt,
                     input int ha, input int hss, input int hse, input int va, input int vss,
                     input int vse, input int hp, input int vp, input int fw,
                     input int h, input int v, input int hs, input int vs, input int bl,
                     input int pe, input int pc, input int le, input int fe, input int fc);
    int ph = k % d;
    int p = k / d;
    int eh = p % ht;
    int ev = (p / ht) % vt;
    int epe = (ph == d - 1) ? 1 : 0;
    int ele = (epe == 1 && eh == ht - 1) ? 1 : 0;
    int efe = (ele == 1 && ev == vt - 1) ? 1 : 0;
    int efc = 0;
`ifdef VGA_TIMING_FRAME_CNT_EN
    efc = (k / (d * ht * vt)) % (1 << fw);
`endif
    cmp($sformatf("%s hcount k=%0d", tag, k), h, eh);
    cmp($sformatf("%s vcount k=%0d", tag, k), v, ev);
    cmp($sformatf("%s hsync k=%0d", tag, k), hs, (eh >= hss && eh <= hse) ? hp : 1 - hp);
    cmp($sformatf("%s vsync k=%0d", tag, k), vs, (ev >= vss && ev <= vse) ? vp : 1 - vp);
    cmp($sformatf("%s blank k=%0d", tag, k), bl, (eh >= ha || ev >= va) ? 1 : 0);
    cmp($sformatf("%s pix_en k=%0d", tag, k), pe, epe);
    cmp($sformatf("%s pix_clk k=%0d", tag, k), pc, (ph >= d / 2) ? 1 : 0);
    cmp($sformatf("%s line_end k=%0d", tag, k), le, ele);
    cmp($sformatf("%s frame_end k=%0d", tag, k), fe, efe);
    cmp($sformatf("%s frame_count k=%0d", tag, k), fc, efc);
  endtask

  task automatic chk_a();
    chk("a", ka, 2, 800, 525, 640, 656, 751, 480, 490, 491, 0, 0, 8, int'(h_a), int'(v_a),
        int'(hs_a), int'(vs_a), int'(bl_a), int'(pe_a), int'(pc_a), int'(le_a), int'(fe_a),
        int'(fc_a));
  endtask

  task automatic run_a(input int c);
    for (int i = 0; i < c; i++) begin
      @(posedge clk);
      ka++;
      @(negedge clk);
      if (ka <= 1600 && !hs_a) hsl++;
      if (ka <= 1600 && le_a) lec++;
      chk_a();
    end
  endtask

  task automatic run_b(input int c);
    for (int i = 0; i < c; i++) begin
      @(posedge clk);
      kb++;
      @(negedge clk);
      if (fe_seen) begin
        fcs.push_back(int'(fc_b));
        fe_seen = 0;
      end
      if (fe_b) begin
        fek.push_back(kb);
        fe_seen = 1;
      end
      if (kb <= 294 && pc_b) pcn++;
      chk("b", kb, 3, 14, 7, 8, 10, 11, 4, 5, 5, 1, 0, 2, int'(h_b), int'(v_b), int'(hs_b),
          int'(vs_b), int'(bl_b), int'(pe_b), int'(pc_b), int'(le_b), int'(fe_b), int'(fc_b));
    end
  endtask

  task automatic run_c(input int c);
    for (int i = 0; i < c; i++) begin
      @(posedge clk);
      kc++;
      @(negedge clk);
      if (kc <= 2432 && vs_c) vsn++;
      chk("c", kc, 4, 32, 19, 20, 24, 29, 10, 13, 14, 0, 1, 8, int'(h_c), int'(v_c),
          int'(hs_c), int'(vs_c), int'(bl_c), int'(pe_c), int'(pc_c), int'(le_c), int'(fe_c),
          int'(fc_c));
    end
  endtask

  typedef struct {
    logic rst;
    int h;
    int pe;
    int pc;
  } vec_t;

  vec_t tv[11];
  int exp_fc[5];

  initial begin
    for (int i = 0; i < 5; i++) tv[i] = '{1'b1, 0, 0, 0};
    tv[5] = '{1'b0, 0, 1, 1};
    tv[6] = '{1'b0, 1, 0, 0};
    tv[7] = '{1'b0, 1, 1, 1};
    tv[8] = '{1'b0, 2, 0, 0};
    tv[9] = '{1'b0, 2, 1, 1};
    tv[10] = '{1'b0, 3, 0, 0};
`ifdef VGA_TIMING_FRAME_CNT_EN
    exp_fc = '{1, 2, 3, 0, 1};
`else
    exp_fc = '{0, 0, 0, 0, 0};
`endif
    @(negedge clk);
    for (int i = 0; i < 11; i++) begin
      rst_a = tv[i].rst;
      @(posedge clk);
      @(negedge clk);
      cmp($sformatf("vec%0d hcount", i), int'(h_a), tv[i].h);
      cmp($sformatf("vec%0d vcount", i), int'(v_a), 0);
      cmp($sformatf("vec%0d pix_en", i), int'(pe_a), tv[i].pe);
      cmp($sformatf("vec%0d pix_clk", i), int'(pc_a), tv[i].pc);
      cmp($sformatf("vec%0d hsync", i), int'(hs_a), 1);
      cmp($sformatf("vec%0d vsync", i), int'(vs_a), 1);
      cmp($sformatf("vec%0d blank", i), int'(bl_a), 0);
      cmp($sformatf("vec%0d line_end", i), int'(le_a), 0);
    end
    ka = 6;
    run_a(2194);
    cmp("a hsync low clks in line 0", hsl, 192);
    cmp("a line_end count in line 0", lec, 1);
    cmp("a pre-reset hcount", int'(h_a), 300);
    cmp("a pre-reset vcount", int'(v_a), 1);
    rst_a = 1'b1;
    @(posedge clk);
    ka = 0;
    @(negedge clk);
    chk_a();
    rst_a = 1'b0;
    run_a(1700);
    rst_a = 1'b1;

    rst_b = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("b rst", 0, 3, 14, 7, 8, 10, 11, 4, 5, 5, 1, 0, 2, int'(h_b), int'(v_b), int'(hs_b),
        int'(vs_b), int'(bl_b), int'(pe_b), int'(pc_b), int'(le_b), int'(fe_b), int'(fc_b));
    rst_b = 1'b0;
    run_b(1480);
    cmp("b pix_clk high clks per frame", pcn, 196);
    cmp("b frame_end count", fek.size(), 5);
    cmp("b first frame_end k", (fek.size() > 0) ? fek[0] : -1, 293);
    for (int i = 1; i < fek.size(); i++)
      cmp($sformatf("b frame_end spacing %0d", i), fek[i] - fek[i-1], 294);
    cmp("b frame_count samples", fcs.size(), 5);
    for (int i = 0; i < fcs.size() && i < 5; i++)
      cmp($sformatf("b frame_count after frame %0d", i + 1), fcs[i], exp_fc[i]);
    rst_b = 1'b1;

    rst_c = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst_c = 1'b0;
    run_c(2 * 2432 + 5);
    cmp("c vsync active clks per frame", vsn, 256);

    $display("== %0d vectors applied, %0d miscompares ==", n, err);
    $finish;
  end
endmodule
